inst_rom_loader: RTL and testbench

- Instruction memory that drives the CPU core's instruction-fetch port: rom_ce/rom_addr in, rom_data out.
- Contents are loaded at boot from a byte stream (e.g. a UART receiver) using a valid/ready handshake.
- Holds the core in reset through cpu_reset until a complete image is stored, then serves fetches with zero-cycle read latency; the core's IF/ID register captures the data.

---
 rtl/inst_rom_loader_pkg.sv | 27 ++
 rtl/inst_mem_1w1r.sv | 31 +++
 rtl/inst_rom_loader.sv | 157 +++++++++++++++
 tb/tb_inst_rom_loader.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_rom_loader_pkg.sv
// Shared definitions for the boot-time instruction ROM loader:
// loader state encodings, bus widths and a byte-assembly helper.
package inst_rom_loader_pkg;

    // Width of one instruction word as seen by the core's fetch port.
    localparam int INSTRUCTION_BUS_W = 32;

    // Width of one element of the load stream.
    localparam int BYTE_BUS_W = 8;

    // Loader states; the core is released from reset only in LOADER_RUN.
    typedef enum logic [1:0] {
        LOADER_WAIT_LEN = 2'd0,
        LOADER_LOAD     = 2'd1,
        LOADER_RUN      = 2'd2,
        LOADER_ERROR    = 2'd3
    } loader_state_t;

    // Appends a new byte below three already received bytes (big-endian order).
    function automatic logic [INSTRUCTION_BUS_W-1:0] append_byte(
        input logic [INSTRUCTION_BUS_W-BYTE_BUS_W-1:0] upper,
        input logic [BYTE_BUS_W-1:0]                   new_byte
    );
        return {upper, new_byte};
    endfunction

endpackage

// File: rtl/inst_mem_1w1r.sv
// Instruction storage: DEPTH x 32 array with one synchronous write port and
// one asynchronous read port. Contents are deliberately not reset so that a
// partially loaded image survives a reset or reload.
module inst_mem_1w1r
    import inst_rom_loader_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic                         clock,
    input  logic                         wr_en,
    input  logic [ADDR_W-1:0]            wr_addr,
    input  logic [INSTRUCTION_BUS_W-1:0] wr_data,
    input  logic [ADDR_W-1:0]            rd_addr,
    output logic [INSTRUCTION_BUS_W-1:0] rd_data
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [INSTRUCTION_BUS_W-1:0] mem [0:DEPTH-1];

    // Store one assembled word whenever the loader completes it.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Zero-latency read so the core's IF/ID register can capture the word directly.
    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/inst_rom_loader.sv
// Boot loader and instruction ROM for the CPU core. A big-endian 32-bit word
// count header is followed by the image bytes; once the image is complete the
// core is released from reset and fetches are served from the stored words.
module inst_rom_loader
    import inst_rom_loader_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic [BYTE_BUS_W-1:0]        in_data,
    output logic                         in_ready,
    input  logic                         reload,
    input  logic                         rom_ce,
    input  logic [31:0]                  rom_addr,
    output logic [INSTRUCTION_BUS_W-1:0] rom_data,
    output logic                         cpu_reset,
    output logic                         load_done,
    output logic                         load_error,
    output logic [ADDR_W:0]              words_loaded
);

    localparam logic [31:0] DEPTH = 32'd1 << ADDR_W;

    loader_state_t state_q;
    loader_state_t state_d;

    logic [1:0]                              byte_cnt_q;
    logic [1:0]                              byte_cnt_d;
    logic [31:0]                             len_q;
    logic [31:0]                             len_d;
    logic [ADDR_W:0]                         words_q;
    logic [ADDR_W:0]                         words_d;
    logic [INSTRUCTION_BUS_W-BYTE_BUS_W-1:0] word_acc_q;
    logic [INSTRUCTION_BUS_W-BYTE_BUS_W-1:0] word_acc_d;

    logic                         accept;
    logic                         mem_we;
    logic [INSTRUCTION_BUS_W-1:0] mem_wdata;
    logic [31:0]                  header_value;
    logic [ADDR_W:0]              words_inc;
    logic [INSTRUCTION_BUS_W-1:0] rd_word;
    logic                         addr_in_range;
    logic                         unused_addr_bits;

    // Bytes are only taken while collecting; reload and reset block the
    // handshake so a byte offered in that cycle is never silently dropped.
    assign in_ready = ((state_q == LOADER_WAIT_LEN) || (state_q == LOADER_LOAD))
                      && !reload && !reset;
    assign accept   = in_valid && in_ready;

    // State register plus header, byte and word counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= LOADER_WAIT_LEN;
            byte_cnt_q <= 2'd0;
            len_q      <= 32'd0;
            words_q    <= '0;
            word_acc_q <= '0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            len_q      <= len_d;
            words_q    <= words_d;
            word_acc_q <= word_acc_d;
        end
    end

    // Next-state logic: header collection, word assembly and completion checks.
    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        len_d        = len_q;
        words_d      = words_q;
        word_acc_d   = word_acc_q;
        mem_we       = 1'b0;
        mem_wdata    = append_byte(word_acc_q, in_data);
        header_value = append_byte(len_q[23:0], in_data);
        words_inc    = words_q + 1'b1;

        if (reload) begin
            state_d    = LOADER_WAIT_LEN;
            byte_cnt_d = 2'd0;
            len_d      = 32'd0;
            words_d    = '0;
        end else begin
            case (state_q)
                LOADER_WAIT_LEN: begin
                    if (accept) begin
                        len_d = header_value;
                        if (byte_cnt_q == 2'd3) begin
                            byte_cnt_d = 2'd0;
                            if (header_value == 32'd0) begin
                                state_d = LOADER_RUN;
                            end else if (header_value > DEPTH) begin
                                state_d = LOADER_ERROR;
                            end else begin
                                state_d = LOADER_LOAD;
                            end
                        end else begin
                            byte_cnt_d = byte_cnt_q + 2'd1;
                        end
                    end
                end
                LOADER_LOAD: begin
                    if (accept) begin
                        word_acc_d = mem_wdata[INSTRUCTION_BUS_W-BYTE_BUS_W-1:0];
                        if (byte_cnt_q == 2'd3) begin
                            mem_we     = 1'b1;
                            words_d    = words_inc;
                            byte_cnt_d = 2'd0;
                            if (32'(words_inc) == len_q) begin
                                state_d = LOADER_RUN;
                            end
                        end else begin
                            byte_cnt_d = byte_cnt_q + 2'd1;
                        end
                    end
                end
                LOADER_RUN: begin
                    state_d = LOADER_RUN;
                end
                LOADER_ERROR: begin
                    state_d = LOADER_ERROR;
                end
                default: begin
                    state_d = LOADER_WAIT_LEN;
                end
            endcase
        end
    end

    // The word array; write address is the count of words already stored.
    inst_mem_1w1r #(
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clock   (clock),
        .wr_en   (mem_we),
        .wr_addr (words_q[ADDR_W-1:0]),
        .wr_data (mem_wdata),
        .rd_addr (rom_addr[ADDR_W+1:2]),
        .rd_data (rd_word)
    );

    // Fetches outside the memory window or with the enable low return zero;
    // the byte offset inside a word is not meaningful for instruction fetch.
    assign addr_in_range    = (rom_addr >> (ADDR_W + 2)) == 32'd0;
    assign unused_addr_bits = ^rom_addr[1:0];
    assign rom_data         = (rom_ce && addr_in_range) ? rd_word : '0;

    assign cpu_reset    = (state_q != LOADER_RUN);
    assign load_done    = (state_q == LOADER_RUN);
    assign load_error   = (state_q == LOADER_ERROR);
    assign words_loaded = words_q;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Bench for inst_rom_loader: a byte-queue model of the load protocol is
// checked against the DUT every cycle, plus directed literal checks.
module tb_inst_rom_loader;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << ADDR_W;

    localparam int PH_HEADER = 0;
    localparam int PH_DATA   = 1;
    localparam int PH_RUN    = 2;
    localparam int PH_FAILED = 3;

    logic            clock;
    logic            reset;
    logic            in_valid;
    logic [7:0]      in_data;
    logic            in_ready;
    logic            reload;
    logic            rom_ce;
    logic [31:0]     rom_addr;
    logic [31:0]     rom_data;
    logic            cpu_reset;
    logic            load_done;
    logic            load_error;
    logic [ADDR_W:0] words_loaded;

    int total = 0;
    int bad   = 0;

    // Model state
    bit          model_live = 0;
    int          m_phase    = PH_HEADER;
    logic [7:0]  m_bytes [$];
    logic [31:0] m_len      = 32'd0;
    int          m_words    = 0;
    logic [31:0] model_mem [int];
    logic        m_take;
    logic [31:0] m_value;

    inst_rom_loader #(
        .ADDR_W (ADDR_W)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .reload       (reload),
        .rom_ce       (rom_ce),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .cpu_reset    (cpu_reset),
        .load_done    (load_done),
        .load_error   (load_error),
        .words_loaded (words_loaded)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Keeps the run bounded even if something stalls.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [31:0] modelFetch(input logic ce, input logic [31:0] addr,
                                               output bit known);
        known = 1'b1;
        if (!ce || addr >= 32'(DEPTH * 4)) return 32'd0;
        if (model_mem.exists(int'(addr / 4))) return model_mem[int'(addr / 4)];
        known = 1'b0;
        return 32'd0;
    endfunction

    // Protocol model: bytes accumulate in a queue; every four form a header or a word.
    always @(posedge clock) begin
        m_take = model_live && in_valid && !reset && !reload
                 && (m_phase == PH_HEADER || m_phase == PH_DATA);
        if (reset || reload) begin
            if (reset) model_live = 1'b1;
            m_phase = PH_HEADER;
            m_bytes.delete();
            m_len   = 32'd0;
            m_words = 0;
        end else if (m_take) begin
            m_bytes.push_back(in_data);
            if (m_bytes.size() == 4) begin
                m_value = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
                m_bytes.delete();
                if (m_phase == PH_HEADER) begin
                    m_len = m_value;
                    if (m_value == 32'd0)             m_phase = PH_RUN;
                    else if (m_value > 32'(DEPTH))    m_phase = PH_FAILED;
                    else                              m_phase = PH_DATA;
                end else begin
                    model_mem[m_words] = m_value;
                    m_words++;
                    if (32'(m_words) == m_len) m_phase = PH_RUN;
                end
            end
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clock) begin
        logic [31:0] exp_data;
        bit          known;
        if (model_live) begin
            checkOutput("in_ready", 32'(in_ready),
                32'((m_phase == PH_HEADER || m_phase == PH_DATA) && !reload && !reset));
            checkOutput("cpu_reset", 32'(cpu_reset), 32'(m_phase != PH_RUN));
            checkOutput("load_done", 32'(load_done), 32'(m_phase == PH_RUN));
            checkOutput("load_error", 32'(load_error), 32'(m_phase == PH_FAILED));
            checkOutput("words_loaded", 32'(words_loaded), 32'(m_words));
            exp_data = modelFetch(rom_ce, rom_addr, known);
            if (known) checkOutput("rom_data", rom_data, exp_data);
        end
    end

    task automatic applyStimulus(input logic v, input logic [7:0] d,
                                 input logic rl, input logic rs);
        in_valid = v;
        in_data  = d;
        reload   = rl;
        reset    = rs;
        @(posedge clock);
        #1;
    endtask

    task automatic clearInputs();
        in_valid = 1'b0;
        reload   = 1'b0;
        reset    = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] b, input int gap);
        applyStimulus(1'b1, b, 1'b0, 1'b0);
        clearInputs();
        repeat (gap) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic sendWord(input logic [31:0] w, input int gap);
        sendByte(w[31:24], gap);
        sendByte(w[23:16], gap);
        sendByte(w[15:8], gap);
        sendByte(w[7:0], gap);
    endtask

    task automatic pulseReload();
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        clearInputs();
        #1;
    endtask

    task automatic fetch(input logic ce, input logic [31:0] addr);
        rom_ce   = ce;
        rom_addr = addr;
        #1;
    endtask

    initial begin
        in_valid = 1'b0;
        in_data  = 8'h00;
        reload   = 1'b0;
        reset    = 1'b0;
        rom_ce   = 1'b0;
        rom_addr = 32'd0;

        // Reset
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        checkOutput("rst_load_done", 32'(load_done), 32'd0);
        checkOutput("rst_load_error", 32'(load_error), 32'd0);
        checkOutput("rst_words", 32'(words_loaded), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
        clearInputs();
        #1;
        checkOutput("idle_in_ready", 32'(in_ready), 32'd1);

        // Two-word image, back to back
        sendWord(32'h00000002, 0);
        sendWord(32'h34010001, 0);
        sendByte(8'h34, 0);
        sendByte(8'h02, 0);
        sendByte(8'h00, 0);
        checkOutput("pre_last_cpu_reset", 32'(cpu_reset), 32'd1);
        sendByte(8'h02, 0);
        checkOutput("img_cpu_reset", 32'(cpu_reset), 32'd0);
        checkOutput("img_words", 32'(words_loaded), 32'd2);
        checkOutput("model_word1", model_mem[1], 32'h34020002);
        fetch(1'b1, 32'h0);
        checkOutput("fetch_0", rom_data, 32'h34010001);
        fetch(1'b1, 32'h6);
        checkOutput("fetch_6", rom_data, 32'h34020002);
        fetch(1'b0, 32'h6);
        checkOutput("fetch_ce0", rom_data, 32'h00000000);

        // Bytes offered in RUN are ignored
        rom_ce = 1'b1;
        sendWord(32'hDEADBEEF, 0);
        checkOutput("run_ignore_words", 32'(words_loaded), 32'd2);
        fetch(1'b1, 32'h0);
        checkOutput("run_ignore_mem", rom_data, 32'h34010001);

        // Zero-length header
        pulseReload();
        checkOutput("reload_cpu_reset", 32'(cpu_reset), 32'd1);
        sendWord(32'h00000000, 0);
        checkOutput("zero_len_done", 32'(load_done), 32'd1);
        checkOutput("zero_len_cpu_reset", 32'(cpu_reset), 32'd0);
        fetch(1'b1, 32'h1000);
        checkOutput("fetch_oob", rom_data, 32'h00000000);
        fetch(1'b1, 32'h4);
        checkOutput("fetch_retained", rom_data, 32'h34020002);

        // Oversized header
        pulseReload();
        sendWord(32'h00000401, 0);
        checkOutput("err_load_error", 32'(load_error), 32'd1);
        checkOutput("err_cpu_reset", 32'(cpu_reset), 32'd1);
        in_valid = 1'b1;
        #1;
        checkOutput("err_in_ready", 32'(in_ready), 32'd0);
        sendWord(32'h00000001, 0);
        checkOutput("err_sticky", 32'(load_error), 32'd1);
        pulseReload();
        checkOutput("err_exit_in_ready", 32'(in_ready), 32'd1);
        checkOutput("err_exit_load_error", 32'(load_error), 32'd0);

        // Full-depth image
        sendWord(32'h00000400, 0);
        for (int i = 0; i < DEPTH; i++) sendWord(32'hC0DE0000 | 32'(i), 0);
        checkOutput("full_words", 32'(words_loaded), 32'h400);
        checkOutput("full_done", 32'(load_done), 32'd1);
        fetch(1'b1, 32'hFFC);
        checkOutput("fetch_last", rom_data, 32'hC0DE03FF);
        fetch(1'b1, 32'h1000);
        checkOutput("fetch_past_end", rom_data, 32'h00000000);
        fetch(1'b1, 32'hFFFFFFFC);
        checkOutput("fetch_high", rom_data, 32'h00000000);

        // Same two-word image with gaps on in_valid
        pulseReload();
        sendWord(32'h00000002, 3);
        sendWord(32'h34010001, 3);
        sendByte(8'h34, 3);
        sendByte(8'h02, 3);
        sendByte(8'h00, 3);
        checkOutput("gap_pre_last", 32'(cpu_reset), 32'd1);
        sendByte(8'h02, 0);
        checkOutput("gap_cpu_reset", 32'(cpu_reset), 32'd0);
        fetch(1'b1, 32'h0);
        checkOutput("gap_fetch_0", rom_data, 32'h34010001);
        fetch(1'b1, 32'h4);
        checkOutput("gap_fetch_4", rom_data, 32'h34020002);

        // Reload colliding with a byte during LOAD
        pulseReload();
        sendWord(32'h00000002, 0);
        sendWord(32'h11223344, 0);
        checkOutput("mid_words", 32'(words_loaded), 32'd1);
        sendByte(8'hAA, 0);
        sendByte(8'hBB, 0);
        in_valid = 1'b1;
        in_data  = 8'hCC;
        reload   = 1'b1;
        #1;
        checkOutput("reload_blocks_ready", 32'(in_ready), 32'd0);
        @(posedge clock);
        #1;
        clearInputs();
        #1;
        checkOutput("reload_words", 32'(words_loaded), 32'd0);
        checkOutput("reload_in_ready", 32'(in_ready), 32'd1);

        // Synchronous reset mid-word, then a fresh one-word image
        sendWord(32'h00000001, 0);
        sendByte(8'h3C, 0);
        sendByte(8'h01, 0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("mid_rst_cpu_reset", 32'(cpu_reset), 32'd1);
        checkOutput("mid_rst_done", 32'(load_done), 32'd0);
        checkOutput("mid_rst_error", 32'(load_error), 32'd0);
        checkOutput("mid_rst_words", 32'(words_loaded), 32'd0);
        checkOutput("mid_rst_in_ready", 32'(in_ready), 32'd0);
        clearInputs();
        sendWord(32'h00000001, 0);
        sendWord(32'h3C01FFFF, 0);
        checkOutput("fresh_done", 32'(load_done), 32'd1);
        fetch(1'b1, 32'h0);
        checkOutput("fresh_fetch_0", rom_data, 32'h3C01FFFF);
        fetch(1'b1, 32'h3);
        checkOutput("fresh_fetch_3", rom_data, 32'h3C01FFFF);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
